// File: rtl/fmab_pkg.sv
// Shared constants and types for the fmab multiply-accumulate unit and its drain stage.
package fmab_pkg;

    localparam int EXP_SUM_BIAS = 254;
    localparam int FP32_BIAS    = 127;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_RUN
    } drain_state_t;

    typedef struct packed {
        logic        sign;
        logic [31:0] mag;
        logic [5:0]  lzc;
        logic [9:0]  exp;
        logic [1:0]  lane;
        logic        valid;
    } lane_rec_t;

endpackage

// File: rtl/fmab_drain_if.sv
// Output beat stream of fmab_drain: one packed lane result per valid/ready handshake.
interface fmab_drain_if;

    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [1:0]  lane;

    modport master (output valid, data, lane, input ready);
    modport slave  (input valid, data, lane, output ready);

endinterface

// File: rtl/fmab_drain_pack.sv
// Normalize, round-to-nearest-even and pack one stage-1 lane record into FP32,
// or into bfloat16 in the low half when FMAB_DRAIN_BF16_EN is defined.
module fmab_drain_pack
    import fmab_pkg::*;
#(
    parameter int ACC_FRAC = 30
) (
    input  lane_rec_t   rec,
    output logic [31:0] data
);

`ifdef FMAB_DRAIN_BF16_EN
    localparam int MANT_W = 7;
`else
    localparam int MANT_W = 23;
`endif
    localparam int GUARD_BIT = 30 - MANT_W;
    localparam int OUT_W     = MANT_W + 9;

    logic [31:0]        norm;
    logic [MANT_W-1:0]  mant;
    logic [MANT_W:0]    mant_rnd;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic signed [11:0] e_norm;
    logic signed [11:0] e_rnd;
    logic [OUT_W-1:0]   packed_val;
    logic               unused_fields;

    // After the shift the leading one sits at bit 31 and is implied in the output format.
    always_comb begin
        norm     = rec.mag << rec.lzc;
        mant     = norm[30 -: MANT_W];
        guard    = norm[GUARD_BIT];
        sticky   = |norm[GUARD_BIT-1:0];
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        e_norm   = 12'(int'(rec.exp) - EXP_SUM_BIAS + FP32_BIAS + 31 - ACC_FRAC - int'(rec.lzc));
        e_rnd    = e_norm + $signed({11'd0, mant_rnd[MANT_W]});
    end

    always_comb begin
        if (rec.mag == 32'd0 || rec.exp == 10'd0) begin
            packed_val = '0;
        end else if (e_rnd >= 12'sd255) begin
            packed_val = {rec.sign, 8'hFF, {MANT_W{1'b0}}};
        end else if (e_rnd <= 12'sd0) begin
            packed_val = {rec.sign, {(OUT_W-1){1'b0}}};
        end else begin
            packed_val = {rec.sign, e_rnd[7:0], mant_rnd[MANT_W-1:0]};
        end
    end

    assign data          = 32'(packed_val);
    assign unused_fields = ^{norm[31], rec.valid, rec.lane};

endmodule

// File: rtl/fmab_drain.sv
// Result-drain stage for fmab: snapshots four lane accumulators and streams them out as
// packed floats, one lane per beat. Defining FMAB_DRAIN_BF16_EN selects bfloat16 output.
module fmab_drain
    import fmab_pkg::*;
#(
    parameter int ACC_FRAC = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [31:0]  acc0,
    input  logic [31:0]  acc1,
    input  logic [31:0]  acc2,
    input  logic [31:0]  acc3,
    input  logic [9:0]   exp0,
    input  logic [9:0]   exp1,
    input  logic [9:0]   exp2,
    input  logic [9:0]   exp3,
    output logic         busy,
    fmab_drain_if.master result
);

    drain_state_t state;
    drain_state_t state_next;
    logic [31:0]  snap_acc [4];
    logic [9:0]   snap_exp [4];
    logic [2:0]   cnt;
    lane_rec_t    s1;
    lane_rec_t    s1_next;
    logic [31:0]  sel_acc;
    logic [31:0]  sel_mag;
    logic [5:0]   sel_lzc;
    logic [31:0]  pack_data;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_lane;
    logic         adv;
    logic         capture;
    logic         last_accept;
    logic         issue;

    assign adv         = !out_valid || result.ready;
    assign capture     = (state == DRAIN_IDLE) && req;
    assign last_accept = out_valid && result.ready && (out_lane == 2'd3);
    // cnt[2] set means all four lanes have entered the pipe; only the tail is draining.
    assign issue       = (state == DRAIN_RUN) && !cnt[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                if (capture) state_next = DRAIN_RUN;
            end
            DRAIN_RUN: begin
                busy = 1'b1;
                if (last_accept) state_next = DRAIN_IDLE;
            end
            default: state_next = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            snap_acc[0] <= acc0;
            snap_acc[1] <= acc1;
            snap_acc[2] <= acc2;
            snap_acc[3] <= acc3;
            snap_exp[0] <= exp0;
            snap_exp[1] <= exp1;
            snap_exp[2] <= exp2;
            snap_exp[3] <= exp3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (capture) begin
            cnt <= 3'd0;
        end else if (issue && adv) begin
            cnt <= cnt + 3'd1;
        end
    end

    // The most negative accumulator maps to magnitude 2^31, which still fits unsigned.
    always_comb begin
        sel_acc = snap_acc[cnt[1:0]];
        sel_mag = sel_acc[31] ? (~sel_acc + 32'd1) : sel_acc;
        sel_lzc = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (sel_mag[i]) sel_lzc = 6'(31 - i);
        end
        s1_next.sign  = sel_acc[31];
        s1_next.mag   = sel_mag;
        s1_next.lzc   = sel_lzc;
        s1_next.exp   = snap_exp[cnt[1:0]];
        s1_next.lane  = cnt[1:0];
        s1_next.valid = issue;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
        end else if (adv) begin
            s1 <= s1_next;
        end
    end

    fmab_drain_pack #(
        .ACC_FRAC (ACC_FRAC)
    ) u_pack (
        .rec  (s1),
        .data (pack_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_lane  <= 2'd0;
        end else if (adv) begin
            out_valid <= s1.valid;
            if (s1.valid) begin
                out_data <= pack_data;
                out_lane <= s1.lane;
            end
        end
    end

    assign result.valid = out_valid;
    assign result.data  = out_data;
    assign result.lane  = out_lane;

endmodule

// File: tb/tb_fmab_drain.sv
// Self-checking bench for fmab_drain: arithmetic float model plus scoreboard, and
// literal expectations for the directed vectors.
module tb_fmab_drain;

    logic        clk;
    logic        reset;
    logic        req;
    logic [31:0] acc0, acc1, acc2, acc3;
    logic [9:0]  exp0, exp1, exp2, exp3;
    logic        busy;

    fmab_drain_if dif ();

    fmab_drain dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .acc0   (acc0),
        .acc1   (acc1),
        .acc2   (acc2),
        .acc3   (acc3),
        .exp0   (exp0),
        .exp1   (exp1),
        .exp2   (exp2),
        .exp3   (exp3),
        .busy   (busy),
        .result (dif)
    );

    always #5 clk = ~clk;

`ifdef FMAB_DRAIN_BF16_EN
    localparam int SIG_BITS = 8;
    localparam logic [31:0] LIT_BASIC [4] = '{32'h00003F80, 32'h0000BF80, 32'h0000BF00, 32'h00000000};
    localparam logic [31:0] LIT_ROUND [4] = '{32'h00003F80, 32'h00003F80, 32'h00004000, 32'h0000C000};
    localparam logic [31:0] LIT_LIMIT [4] = '{32'h00007F80, 32'h00008000, 32'h00000000, 32'h0000FF80};
`else
    localparam int SIG_BITS = 24;
    localparam logic [31:0] LIT_BASIC [4] = '{32'h3F800000, 32'hBF800000, 32'hBF000000, 32'h00000000};
    localparam logic [31:0] LIT_ROUND [4] = '{32'h3F800000, 32'h3F800002, 32'h40000000, 32'hC0000000};
    localparam logic [31:0] LIT_LIMIT [4] = '{32'h7F800000, 32'h80000000, 32'h00000000, 32'hFF800000};
`endif

    typedef struct {
        logic [1:0]  lane;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          model_busy = 0;
    int          since_cap = 0;
    int          beats_seen = 0;
    int          run_base = 0;
    logic [31:0] lane_data [4];

    // Value = acc * 2^(exp - 254 - 30); find the top bit, keep SIG_BITS, round half to even.
    function automatic logic [31:0] model_pack(input logic [31:0] acc, input logic [9:0] ex);
        longint m, q, r, half;
        int     msb, e, sh;
        logic   s;
        if (acc == 32'd0 || ex == 10'd0) return 32'd0;
        s   = acc[31];
        m   = s ? (64'd4294967296 - longint'({32'd0, acc})) : longint'({32'd0, acc});
        msb = 0;
        for (int i = 0; i < 33; i++) if (m[i]) msb = i;
        e  = msb + int'(ex) - 254 - 30 + 127;
        sh = msb - (SIG_BITS - 1);
        if (sh > 0) begin
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
        end else begin
            q = m << (-sh);
        end
        if (q == (64'sd1 << SIG_BITS)) begin
            q = q >> 1;
            e = e + 1;
        end
`ifdef FMAB_DRAIN_BF16_EN
        if (e >= 255) return {16'h0, s, 8'hFF, 7'd0};
        if (e <= 0) return {16'h0, s, 15'd0};
        return {16'h0, s, 8'(e), q[6:0]};
`else
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), q[22:0]};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a0, a1, a2, a3, input logic [9:0] e0, e1, e2, e3);
        @(negedge clk);
        run_base = beats_seen;
        for (int i = 0; i < 4; i++) lane_data[i] = 32'hDEADBEEF;
        acc0 = a0; acc1 = a1; acc2 = a2; acc3 = a3;
        exp0 = e0; exp1 = e1; exp2 = e2; exp3 = e3;
        req  = 1'b1;
        @(negedge clk);
        req  = 1'b0;
    endtask

    task automatic waitBeats();
        int n = 0;
        while (beats_seen < run_base + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (beats_seen < run_base + 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: actual=%0d required=%0d", beats_seen - run_base, 4);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic waitLane(input logic [1:0] lane);
        int n = 0;
        while (!(dif.valid && dif.lane == lane) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(dif.valid && dif.lane == lane)) begin
            checks++;
            errors++;
            $display("[TB] FAIL lane_timeout: actual=%0d required=%0d", dif.lane, lane);
        end
    endtask

    task automatic checkRun(input string tag, input logic [31:0] l0, l1, l2, l3);
        checkOutput({tag, "_lane0"}, lane_data[0], l0);
        checkOutput({tag, "_lane1"}, lane_data[1], l1);
        checkOutput({tag, "_lane2"}, lane_data[2], l2);
        checkOutput({tag, "_lane3"}, lane_data[3], l3);
    endtask

    // Compare process: outputs are predicted from the model, then the model advances one edge.
    initial begin : compare_proc
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [1:0]  prev_lane;
        logic        exp_valid;
        int          busy_before;
        beat_t       b;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        prev_lane  = 2'd0;
        forever begin
            @(negedge clk);
            #1;
            exp_valid = (model_busy != 0) && (since_cap >= 2);
            checkOutput("busy", 32'(busy), 32'(model_busy != 0));
            checkOutput("valid", 32'(dif.valid), 32'(exp_valid));
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard: actual=empty required=pending beat");
                end else begin
                    checkOutput("lane", 32'(dif.lane), 32'(exp_q[0].lane));
                    checkOutput("data", dif.data, exp_q[0].data);
                end
            end
            if (prev_stall) begin
                checkOutput("hold_data", dif.data, prev_data);
                checkOutput("hold_lane", 32'(dif.lane), 32'(prev_lane));
            end
            prev_stall  = dif.valid && !dif.ready && !reset;
            prev_data   = dif.data;
            prev_lane   = dif.lane;
            busy_before = model_busy;
            if (reset) begin
                exp_q.delete();
                model_busy = 0;
                since_cap  = 0;
            end else begin
                if (model_busy != 0 && since_cap < 1000) since_cap++;
                if (exp_valid && dif.ready && exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    lane_data[b.lane] = dif.data;
                    beats_seen++;
                    if (b.lane == 2'd3) model_busy = 0;
                end
                if (busy_before == 0 && req) begin
                    b.lane = 2'd0; b.data = model_pack(acc0, exp0); exp_q.push_back(b);
                    b.lane = 2'd1; b.data = model_pack(acc1, exp1); exp_q.push_back(b);
                    b.lane = 2'd2; b.data = model_pack(acc2, exp2); exp_q.push_back(b);
                    b.lane = 2'd3; b.data = model_pack(acc3, exp3); exp_q.push_back(b);
                    model_busy = 1;
                    since_cap  = 0;
                end
            end
        end
    end

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        req = 1'b0;
        dif.ready = 1'b1;
        acc0 = '0; acc1 = '0; acc2 = '0; acc3 = '0;
        exp0 = '0; exp1 = '0; exp2 = '0; exp3 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", 32'(dif.valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_data", dif.data, 32'd0);
        checkOutput("rst_lane", 32'(dif.lane), 32'd0);

        checkOutput("model_one", model_pack(32'h40000000, 10'd254), LIT_BASIC[0]);
        checkOutput("model_tie", model_pack(32'h40000040, 10'd254), LIT_ROUND[0]);
        checkOutput("model_carry", model_pack(32'h7FFFFFFF, 10'd254), LIT_ROUND[2]);
        checkOutput("model_ovf", model_pack(32'h40000000, 10'd600), LIT_LIMIT[0]);
        checkOutput("model_flush", model_pack(32'hC0000000, 10'd20), LIT_LIMIT[1]);

        applyStimulus(32'h40000000, 32'hC0000000, 32'hE0000000, 32'h00000000, 10'd254, 10'd254, 10'd254, 10'd254);
        waitBeats();
        checkRun("basic", LIT_BASIC[0], LIT_BASIC[1], LIT_BASIC[2], LIT_BASIC[3]);

        applyStimulus(32'h40000040, 32'h400000C0, 32'h7FFFFFFF, 32'h80000000, 10'd254, 10'd254, 10'd254, 10'd254);
        waitBeats();
        checkRun("round", LIT_ROUND[0], LIT_ROUND[1], LIT_ROUND[2], LIT_ROUND[3]);

        applyStimulus(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000, 10'd600, 10'd20, 10'd0, 10'd600);
        waitBeats();
        checkRun("limit", LIT_LIMIT[0], LIT_LIMIT[1], LIT_LIMIT[2], LIT_LIMIT[3]);

        // Backpressure at lane 1, input changes after capture, req while busy and at lane-3 accept.
        applyStimulus(32'h40000000, 32'hC0000000, 32'hE0000000, 32'h00000000, 10'd254, 10'd254, 10'd254, 10'd254);
        acc0 = 32'h12345678; acc1 = 32'h7FFFFFFF; exp0 = 10'd300; exp1 = 10'd600;
        repeat (3) @(negedge clk);
        dif.ready = 1'b0;
        req = 1'b1;
        acc2 = 32'h40000000; exp2 = 10'd400;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        dif.ready = 1'b1;
        waitLane(2'd3);
        req = 1'b1;
        acc3 = 32'h55555555; exp3 = 10'd260;
        @(negedge clk);
        req = 1'b0;
        waitBeats();
        checkRun("bp", LIT_BASIC[0], LIT_BASIC[1], LIT_BASIC[2], LIT_BASIC[3]);

        // Reset while lane 2 is on the output discards the remaining lanes.
        applyStimulus(32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000, 10'd600, 10'd20, 10'd0, 10'd600);
        waitLane(2'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_valid", 32'(dif.valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        applyStimulus(32'h40000040, 32'h400000C0, 32'h7FFFFFFF, 32'h80000000, 10'd254, 10'd254, 10'd254, 10'd254);
        waitBeats();
        checkRun("post_rst", LIT_ROUND[0], LIT_ROUND[1], LIT_ROUND[2], LIT_ROUND[3]);

        repeat (5) @(negedge clk);
        checkOutput("drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmab_drain.md
# fmab_drain

Result-drain stage for the `fmab` 4-lane multiply-accumulate unit. It snapshots the four lane accumulators (32-bit signed fixed-point) and their 10-bit biased-sum exponents, then normalizes, rounds and packs each lane into an IEEE-754 single. Results stream out one lane per beat over a valid/ready interface. It sits between the MAC array and the write-back/store path, converting internal accumulator format back to memory float format.

## Interface
- `ACC_FRAC`, 30: fraction bits of `accN` relative to exponent `expN − 254`
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset
- `req` in 1: capture pulse; sampled only when `busy`=0
- `acc0..acc3` in 32 each: lane accumulators, two's complement
- `exp0..exp3` in 10 each: lane exponents, sum of two 127-biased exponents (bias 254); 0 = lane is zero
- `busy` out 1: snapshot held, lanes not all delivered
- `out_valid` out 1: `out_data`/`out_lane` valid
- `out_ready` in 1: consumer accepts the beat when `out_valid & out_ready`
- `out_data` out 32: packed result
- `out_lane` out 2: lane index of `out_data`

## Operation
- Lane value = `acc` × 2^(`exp` − 254 − `ACC_FRAC`).
- Capture: `req & !busy` at an edge latches all acc/exp into snapshot registers; `busy` set; lane counter = 0. `req` while `busy`=1 is ignored, with no queueing.
- FSM: IDLE → RUN on capture. In RUN the counter issues lanes 0,1,2,3 into the pipe. RUN → IDLE when lane 3 is accepted at the output.
- Stage 1 (per lane): sign = acc[31]; mag = |acc| as 32-bit unsigned, so 0x80000000 gives magnitude 2^31; lzc = leading-zero count of mag.
- Stage 2: shift mag left by lzc (leading one at bit 31).
  - E = exp − 127 + 31 − `ACC_FRAC` − lzc, computed signed at ≥12 bits.
  - Mantissa = bits[30:8]; guard = bit 7; sticky = OR of bits[6:0].
  - Rounding is round-to-nearest-even. A mantissa carry-out increments E.
- Special cases:
  - mag=0 or exp=0: +0 (0x00000000).
  - E ≥ 255 after rounding: signed infinity.
  - E ≤ 0: signed zero (flush; no denormals).
- Stall: a global advance enable = `!out_valid | out_ready`. When it is low, the counter, stage 1 and the output register all hold. `out_data`/`out_lane` stay stable while `out_valid & !out_ready`.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_lane`=0, FSM=IDLE, counter=0, pipe valids=0.
- Latency: capture at edge N → stage 1 at N+1 → `out_valid` high after edge N+2 with lane 0.
- Throughput: with `out_ready`=1, lanes 1..3 follow at N+3, N+4, N+5. `busy` falls after the edge accepting lane 3, so the earliest next capture is that same edge +1.
- `req` in the cycle lane 3 is accepted is ignored (`busy` still 1).
- `reset` mid-RUN: all state cleared next edge; partial lanes are discarded.
- Snapshot registers are immune to input changes after capture.

## Configuration
- `FMAB_DRAIN_BF16_EN` defined: round to 7 mantissa bits (guard = bit 23, sticky = bits[22:0] after normalize).
  - Output is bfloat16 in `out_data[15:0]`, with `out_data[31:16]`=0.
  - Overflow/flush rules are unchanged; infinity = 0x7F80/0xFF80.
- Undefined: FP32 as above.

## Structure
- Shared `fmab_pkg` holds:
  - constants `EXP_SUM_BIAS`=254 and `FP32_BIAS`=127;
  - a typedef for the stage-1 lane record (sign, mag, lzc, exp, lane, valid).
- One sub-module, `fmab_drain_pack`: combinational normalize/round/pack from the stage-1 record to packed result, configured by the macro.
- LZC, FSM, snapshot and handshake are in the top.

## Test plan
- acc0=0x40000000, exp0=254, `out_ready`=1 → lane 0 = 0x3F800000 at N+2. acc1=0xC0000000 → 0xBF800000; acc2=0xE0000000 → 0xBF000000; acc3=0 → 0x00000000. Lanes arrive at consecutive cycles and `busy` drops after lane 3.
- Rounding at exp=254:
  - acc=0x40000040 (tie, even) → 0x3F800000;
  - acc=0x400000C0 → 0x3F800002;
  - acc=0x7FFFFFFF → 0x40000000, checking that mantissa carry-out increments E.
- Limits:
  - acc=0x40000000 with exp=600 → 0x7F800000;
  - same acc with exp=20 → 0x00000000;
  - acc=0x80000000 with exp=254 → 0xC0000000.
- Backpressure: hold `out_ready`=0 for 5 cycles at lane 1 → `out_data`/`out_lane` stay stable. Releasing it gives lanes 1,2,3 back-to-back with none lost or duplicated.
- `req` pulsed while `busy`, and in the lane-3 accept cycle, with different inputs → ignored; outputs come from the original snapshot.
- `reset` asserted at lane 2 → next cycle `out_valid`=0 and `busy`=0; a new `req` then runs normally.
- With `FMAB_DRAIN_BF16_EN` defined: acc=0x40000000, exp=254 → 0x00003F80.
